// File: rtl/irq_encoder.sv
// irq_encoder: three-source interrupt controller with sync, edge/level latch, mask, priority and
// in-service tracking. Define IRQ_NESTING_EN to let higher-priority sources preempt a running handler.
module irq_encoder #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_TRIG   = 1'b1
) (
   input  logic       in_clk,
   input  logic       in_rst_n,
   input  logic [2:0] in_irq,
   input  logic [2:0] in_mask,
   input  logic       in_ie,
   input  logic       in_ack,
   input  logic       in_eret,
   output logic       out_irq,
   output logic [1:0] out_code,
   output logic [2:0] out_pending,
   output logic [2:0] out_isr
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

   function automatic logic [1:0] prio_code(input logic [2:0] bits);
      logic [1:0] code;
      if (bits[2])      code = 2'd3;
      else if (bits[1]) code = 2'd2;
      else if (bits[0]) code = 2'd1;
      else              code = 2'd0;
      return code;
   endfunction

   function automatic logic [2:0] code_onehot(input logic [1:0] code);
      logic [2:0] oh;
      case (code)
         2'd1:    oh = 3'b001;
         2'd2:    oh = 3'b010;
         2'd3:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0] prev_q;
   logic [2:0] pending_q, pending_d;
   logic [2:0] isr_q, isr_d;
   state_t     state_q, state_d;
   logic [1:0] code_q, code_d;
   logic       irq_q, irq_d;

   logic [2:0] sync_s, set_s, allow_s, eligible_s, pend_clr_s, isr_set_s, isr_clr_s;
   logic [1:0] top_isr_s;

   assign sync_s     = sync_q[SYNC_STAGES-1];
   assign set_s      = EDGE_TRIG ? (sync_s & ~prev_q) : sync_s;
   assign top_isr_s  = prio_code(isr_q);
   assign isr_clr_s  = in_eret ? code_onehot(top_isr_s) : 3'b000;
   assign eligible_s = pending_q & in_mask & {3{in_ie}} & allow_s;

   // Priority gate: which sources may be offered given the handlers already in service.
   always_comb begin
      allow_s = 3'b000;
`ifdef IRQ_NESTING_EN
      case (top_isr_s)
         2'd0:    allow_s = 3'b111;
         2'd1:    allow_s = 3'b110;
         2'd2:    allow_s = 3'b100;
         default: allow_s = 3'b000;
      endcase
`else
      if (isr_q == 3'b000) begin
         allow_s = 3'b111;
      end else begin
         allow_s = 3'b000;
      end
`endif
   end

   // Request FSM: code is frozen once offered, so the CPU is never handed a moving target.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      irq_d      = 1'b0;
      pend_clr_s = 3'b000;
      isr_set_s  = 3'b000;
      case (state_q)
         ST_IDLE: begin
            if (eligible_s != 3'b000) begin
               state_d = ST_REQ;
               code_d  = prio_code(eligible_s);
               irq_d   = 1'b1;
            end else begin
               code_d  = 2'd0;
            end
         end
         ST_REQ: begin
            if (in_ack) begin
               state_d    = ST_IDLE;
               code_d     = 2'd0;
               irq_d      = 1'b0;
               pend_clr_s = code_onehot(code_q);
               isr_set_s  = code_onehot(code_q);
            end else begin
               irq_d      = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            code_d  = 2'd0;
         end
      endcase
   end

   // Set after clear so an edge arriving with the ack of the same source is kept;
   // eret removes the old top level before ack adds the new one.
   assign pending_d = (pending_q & ~pend_clr_s) | set_s;
   assign isr_d     = (isr_q & ~isr_clr_s) | isr_set_s;

   // State registers.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         sync_q    <= '0;
         prev_q    <= 3'b000;
         pending_q <= 3'b000;
         isr_q     <= 3'b000;
         state_q   <= ST_IDLE;
         code_q    <= 2'd0;
         irq_q     <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], in_irq};
         prev_q    <= sync_s;
         pending_q <= pending_d;
         isr_q     <= isr_d;
         state_q   <= state_d;
         code_q    <= code_d;
         irq_q     <= irq_d;
      end
   end

   assign out_irq     = irq_q;
   assign out_code    = code_q;
   assign out_pending = pending_q;
   assign out_isr     = isr_q;

endmodule
